// File: rtl/ram_arbiter.sv
// Round-robin arbiter sequencing instruction-fetch and data-memory word requests
// onto a single byte-wide RAM, assembling read bytes little-endian.
module ram_arbiter #(
    parameter int MAX_IBYTES = 6
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_req,
    input  logic [31:0]             i_addr,
    input  logic [2:0]              i_len,
    output logic                    i_done,
    output logic [8*MAX_IBYTES-1:0] i_rdata,
    input  logic                    d_req,
    input  logic                    d_we,
    input  logic [31:0]             d_addr,
    input  logic [31:0]             d_wdata,
    output logic                    d_done,
    output logic [31:0]             d_rdata,
    output logic [31:0]             ram_addr,
    output logic [7:0]              ram_wdata,
    input  logic [7:0]              ram_rdata,
    output logic                    ram_we,
    output logic                    ram_re,
    output logic                    busy,
    output logic                    owner
);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    localparam logic [2:0] MAX_LEN = 3'(MAX_IBYTES);

    state_t                  state_q, state_d;
    logic [2:0]              cnt_q, cnt_d;
    logic [2:0]              len_q, len_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic                    we_q, we_d;
    logic [31:0]             base_q, base_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             d_rdata_q, d_rdata_d;
    logic [8*MAX_IBYTES-1:0] i_rdata_q, i_rdata_d;
    logic [2:0]              i_len_eff;
    logic                    xfer;

    always_comb begin
        i_len_eff = i_len;
        if (i_len == 3'd0)
            i_len_eff = 3'd1;
        else if (i_len > MAX_LEN)
            i_len_eff = MAX_LEN;
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        base_d       = base_q;
        wdata_d      = wdata_q;
        d_rdata_d    = d_rdata_q;
        i_rdata_d    = i_rdata_q;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    // On a tie, the port that lost last time wins (last_grant=0 favours data).
                    owner_d      = d_req & (~i_req | ~last_grant_q);
                    last_grant_d = owner_d;
                    base_d       = owner_d ? d_addr : i_addr;
                    len_d        = owner_d ? 3'd4 : i_len_eff;
                    we_d         = owner_d & d_we;
                    wdata_d      = d_wdata;
                    cnt_d        = 3'd0;
                    state_d      = XFER;
                    if (!owner_d)
                        i_rdata_d = '0;
                end
            end
            XFER: begin
                if (!we_q) begin
                    if (owner_q) begin
                        for (int k = 0; k < 4; k++)
                            if (cnt_q == 3'(k)) d_rdata_d[8*k +: 8] = ram_rdata;
                    end else begin
                        for (int k = 0; k < MAX_IBYTES; k++)
                            if (cnt_q == 3'(k)) i_rdata_d[8*k +: 8] = ram_rdata;
                    end
                end
                if (cnt_q == len_q - 3'd1)
                    state_d = DONE;
                else
                    cnt_d = cnt_q + 3'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= 3'd0;
            len_q        <= 3'd0;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b0;
            we_q         <= 1'b0;
            base_q       <= 32'd0;
            wdata_q      <= 32'd0;
            d_rdata_q    <= 32'd0;
            i_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            base_q       <= base_d;
            wdata_q      <= wdata_d;
            d_rdata_q    <= d_rdata_d;
            i_rdata_q    <= i_rdata_d;
        end
    end

    assign xfer     = (state_q == XFER);
    assign ram_addr = xfer ? base_q + {29'd0, cnt_q} : 32'd0;
    assign ram_re   = xfer & ~we_q;
    assign ram_we   = xfer & we_q;
    assign i_done   = (state_q == DONE) & ~owner_q;
    assign d_done   = (state_q == DONE) & owner_q;
    assign busy     = (state_q != IDLE);
    assign owner    = owner_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;

    always_comb begin
        ram_wdata = 8'd0;
        if (xfer && we_q)
            for (int k = 0; k < 4; k++)
                if (cnt_q == 3'(k)) ram_wdata = wdata_q[8*k +: 8];
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a 512-byte RAM model aliased on addr[8:0];
// RAM byte i holds i[7:0]^A5 except 0x100..0x103 = 11,22,33,44.
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [2:0]  i_len;
    logic        i_done, d_done, ram_we, ram_re, busy, owner;
    logic [47:0] i_rdata;
    logic [31:0] d_rdata, ram_addr;
    logic [7:0]  ram_wdata, ram_rdata;
    logic [7:0]  mem [512];
    int          n_chk = 0;
    int          n_fail = 0;

    ram_arbiter #(.MAX_IBYTES(6)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_len(i_len), .i_done(i_done), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .ram_we(ram_we), .ram_re(ram_re), .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    assign ram_rdata = mem[ram_addr[8:0]];

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 512; i++) mem[i] <= 8'(i) ^ 8'hA5;
            mem[256] <= 8'h11; mem[257] <= 8'h22; mem[258] <= 8'h33; mem[259] <= 8'h44;
        end else if (ram_we) begin
            mem[ram_addr[8:0]] <= ram_wdata;
        end
    end

    task automatic step;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0; i_len = 0;
        step(); step();
        n_chk++;
        if ({busy, owner, i_done, d_done, ram_we, ram_re} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl got %b exp 000000", {busy, owner, i_done, d_done, ram_we, ram_re});
        end
        n_chk++;
        if ({i_rdata, d_rdata, ram_addr, ram_wdata} !== '0) begin
            n_fail++; $display("FAIL reset_data i_rdata=%h d_rdata=%h ram_addr=%h ram_wdata=%h exp 0", i_rdata, d_rdata, ram_addr, ram_wdata);
        end
        reset = 1'b0;
        step();
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_req busy=%b exp 0", busy);
        end
    endtask

    // Both requests held: data, fetch, data, fetch with one IDLE cycle between.
    task automatic test_contention;
        logic exp_own;
        int   exp_len;
        d_we = 0; d_addr = 32'h104; i_addr = 32'h0; i_len = 3'd2;
        i_req = 1; d_req = 1;
        for (int t = 0; t < 4; t++) begin
            exp_own = (t % 2 == 0);
            exp_len = exp_own ? 4 : 2;
            step();
            for (int c = 0; c < exp_len; c++) begin
                n_chk++;
                if (!(busy === 1'b1 && owner === exp_own && ram_re === 1'b1 && i_done === 1'b0 && d_done === 1'b0)) begin
                    n_fail++; $display("FAIL contention_xfer t=%0d c=%0d busy=%b owner=%b re=%b exp owner=%b", t, c, busy, owner, ram_re, exp_own);
                end
                step();
            end
            n_chk++;
            if ({ram_re, ram_we, i_done, d_done, owner} !== {1'b0, 1'b0, ~exp_own, exp_own, exp_own}) begin
                n_fail++; $display("FAIL contention_done t=%0d got %b exp %b", t, {ram_re, ram_we, i_done, d_done, owner}, {1'b0, 1'b0, ~exp_own, exp_own, exp_own});
            end
            step();
            n_chk++;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL contention_gap t=%0d busy=%b exp 0", t, busy);
            end
        end
        i_req = 0; d_req = 0;
        n_chk++;
        if (d_rdata !== 32'hA2A3A0A1 || i_rdata !== 48'h0000_0000_A4A5) begin
            n_fail++; $display("FAIL contention_rdata d=%h i=%h exp d=a2a3a0a1 i=00000000a4a5", d_rdata, i_rdata);
        end
    endtask

    task automatic test_data_read;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        d_req = 0; d_addr = 32'h55;
        for (int c = 0; c < 4; c++) begin
            n_chk++;
            if (!(ram_re === 1'b1 && ram_we === 1'b0 && ram_addr === 32'h100 + 32'(c) && d_done === 1'b0)) begin
                n_fail++; $display("FAIL rd_byte c=%0d re=%b we=%b addr=%h exp addr=%h", c, ram_re, ram_we, ram_addr, 32'h100 + 32'(c));
            end
            step();
        end
        n_chk++;
        if (!(d_done === 1'b1 && i_done === 1'b0 && ram_re === 1'b0 && ram_addr === 32'h0)) begin
            n_fail++; $display("FAIL rd_done d_done=%b i_done=%b re=%b addr=%h exp 1 0 0 0", d_done, i_done, ram_re, ram_addr);
        end
        step();
        n_chk++;
        if (d_done !== 1'b0 || busy !== 1'b0 || d_rdata !== 32'h44332211) begin
            n_fail++; $display("FAIL rd_result d_done=%b busy=%b d_rdata=%h exp 0 0 44332211", d_done, busy, d_rdata);
        end
    endtask

    task automatic test_data_write;
        logic [31:0] wd;
        wd = 32'hDEADBEEF;
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = wd;
        step();
        d_req = 0; d_wdata = 32'h0;
        for (int c = 0; c < 4; c++) begin
            n_chk++;
            if (!(ram_we === 1'b1 && ram_re === 1'b0 && ram_addr === 32'h20 + 32'(c) && ram_wdata === wd[8*c +: 8])) begin
                n_fail++; $display("FAIL wr_byte c=%0d we=%b re=%b addr=%h wdata=%h exp wdata=%h", c, ram_we, ram_re, ram_addr, ram_wdata, wd[8*c +: 8]);
            end
            step();
        end
        n_chk++;
        if (!(d_done === 1'b1 && ram_we === 1'b0 && ram_wdata === 8'h0)) begin
            n_fail++; $display("FAIL wr_done d_done=%b we=%b wdata=%h exp 1 0 00", d_done, ram_we, ram_wdata);
        end
        step();
        n_chk++;
        if (d_done !== 1'b0 || d_rdata !== 32'h44332211 || {mem[9'h23], mem[9'h22], mem[9'h21], mem[9'h20]} !== wd) begin
            n_fail++; $display("FAIL wr_result d_done=%b d_rdata=%h ram=%h exp 0 44332211 deadbeef", d_done, d_rdata, {mem[9'h23], mem[9'h22], mem[9'h21], mem[9'h20]});
        end
        d_we = 0;
    endtask

    task automatic test_fetch;
        logic [31:0] addrs [3] = '{32'h0, 32'h10, 32'h100};
        logic [2:0]  lens  [3] = '{3'd6, 3'd0, 3'd7};
        int          elens [3] = '{6, 1, 6};
        logic [47:0] exps  [3] = '{48'hA0A1A6A7A4A5, 48'h0000000000B5, 48'hA0A144332211};
        for (int v = 0; v < 3; v++) begin
            i_req = 1; i_addr = addrs[v]; i_len = lens[v];
            step();
            i_req = 0; i_len = 3'd3;
            for (int c = 0; c < elens[v]; c++) begin
                n_chk++;
                if (!(ram_re === 1'b1 && ram_addr === addrs[v] + 32'(c) && i_done === 1'b0 && owner === 1'b0)) begin
                    n_fail++; $display("FAIL fetch_byte v=%0d c=%0d re=%b addr=%h i_done=%b exp addr=%h", v, c, ram_re, ram_addr, i_done, addrs[v] + 32'(c));
                end
                step();
            end
            n_chk++;
            if (!(i_done === 1'b1 && d_done === 1'b0 && ram_re === 1'b0)) begin
                n_fail++; $display("FAIL fetch_done v=%0d i_done=%b d_done=%b re=%b exp 1 0 0", v, i_done, d_done, ram_re);
            end
            step();
            n_chk++;
            if (busy !== 1'b0 || i_rdata !== exps[v] || d_rdata !== 32'h44332211) begin
                n_fail++; $display("FAIL fetch_result v=%0d busy=%b i_rdata=%h d_rdata=%h exp 0 %h 44332211", v, busy, i_rdata, d_rdata, exps[v]);
            end
        end
    endtask

    task automatic test_wrap;
        logic [31:0] ea [4] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'h0, 32'h1};
        d_req = 1; d_we = 0; d_addr = 32'hFFFFFFFE;
        step();
        d_req = 0;
        for (int c = 0; c < 4; c++) begin
            n_chk++;
            if (ram_addr !== ea[c] || ram_re !== 1'b1) begin
                n_fail++; $display("FAIL wrap_addr c=%0d addr=%h re=%b exp %h 1", c, ram_addr, ram_re, ea[c]);
            end
            step();
        end
        step();
        n_chk++;
        if (d_rdata !== 32'hA4A55A5B) begin
            n_fail++; $display("FAIL wrap_rdata got %h exp a4a55a5b", d_rdata);
        end
    endtask

    task automatic test_reset_mid;
        d_req = 1; d_we = 0; d_addr = 32'h100;
        step();
        d_req = 0;
        step();
        n_chk++;
        if (ram_re !== 1'b1 || ram_addr !== 32'h101) begin
            n_fail++; $display("FAIL rst_mid_pre re=%b addr=%h exp 1 00000101", ram_re, ram_addr);
        end
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if ({ram_re, ram_we, busy, d_done} !== 4'b0 || d_rdata !== 32'h0 || ram_addr !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_abort ctrl=%b d_rdata=%h addr=%h exp 0", {ram_re, ram_we, busy, d_done}, d_rdata, ram_addr);
        end
        step();
        n_chk++;
        if (d_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_hold d_done=%b busy=%b exp 0 0", d_done, busy);
        end
        reset = 1'b0;
        d_req = 1; d_addr = 32'h104;
        step();
        d_req = 0;
        for (int c = 0; c < 4; c++) begin
            n_chk++;
            if (ram_re !== 1'b1 || d_done !== 1'b0) begin
                n_fail++; $display("FAIL rst_mid_again c=%0d re=%b d_done=%b exp 1 0", c, ram_re, d_done);
            end
            step();
        end
        n_chk++;
        if (d_done !== 1'b1) begin
            n_fail++; $display("FAIL rst_mid_done d_done=%b exp 1", d_done);
        end
        step();
        n_chk++;
        if (d_rdata !== 32'hA2A3A0A1) begin
            n_fail++; $display("FAIL rst_mid_rdata got %h exp a2a3a0a1", d_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_contention();
        test_data_read();
        test_data_write();
        test_fetch();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Arbitrates and sequences the single byte-wide program/data RAM between two word-level requesters: instruction fetch (variable length, 1-6 bytes) and data memory (4-byte read or write).
- Sits between the fetch/memory stages of the Y86 core and the RAM.
- Converts each granted request into consecutive byte accesses, assembles read bytes little-endian, and signals a one-cycle done to the owning requester.

Parameters:
- MAX_IBYTES, 6, maximum fetch length in bytes. Sizes i_rdata as 8*MAX_IBYTES.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- i_req  input  1  fetch request; level, sampled only in IDLE
- i_addr  input  32  fetch start byte address
- i_len  input  3  fetch byte count
- i_done  output  1  one-cycle pulse: fetch complete, i_rdata valid
- i_rdata  output  8*MAX_IBYTES  fetched bytes; byte k at bits [8k+7:8k]
- d_req  input  1  data request; level, sampled only in IDLE
- d_we  input  1  1=write, 0=read; sampled with d_req
- d_addr  input  32  data start byte address
- d_wdata  input  32  write data, little-endian
- d_done  output  1  one-cycle pulse: data access complete
- d_rdata  output  32  read data, little-endian
- ram_addr  output  32  RAM byte address
- ram_wdata  output  8  RAM write byte
- ram_rdata  input  8  RAM read byte; combinational with ram_addr
- ram_we  output  1  RAM write strobe
- ram_re  output  1  RAM read strobe
- busy  output  1  transfer in progress (state != IDLE)
- owner  output  1  current/last grant: 0=fetch, 1=data

Behaviour:
- Reset (async) values: state=IDLE, cnt=0, owner=0, last_grant=0, i_done=0, d_done=0, i_rdata=0, d_rdata=0, ram_we=0, ram_re=0, ram_addr=0, ram_wdata=0, busy=0.
- FSM states: IDLE, XFER, DONE.
- IDLE, at a clock edge:
  - Only one request high: grant it.
  - Both high: grant the port that did NOT win the previous grant (round-robin on last_grant). After reset, data wins the first tie.
  - On grant, latch address, length, write enable and write data; set owner and last_grant; set cnt=0; go to XFER.
  - No request: stay in IDLE.
- Latched length:
  - Data accesses are always 4 bytes.
  - Fetch length is i_len, with i_len=0 treated as 1 and i_len>MAX_IBYTES clamped to MAX_IBYTES.
- XFER, combinational outputs:
  - ram_addr = base + cnt, modulo 2^32; 0xFFFFFFFF+1 wraps to 0.
  - ram_re = ~we_latched; ram_we = we_latched.
  - ram_wdata = wdata byte cnt during writes, 0 otherwise.
- XFER, each clock edge:
  - On a read, capture ram_rdata into byte cnt of the owner's read register.
  - If cnt == len-1, go to DONE; else cnt+1.
  - Bytes of the owner's register beyond len are cleared at grant.
- DONE: exactly one cycle.
  - Assert i_done or d_done per owner; strobes low; ram_addr=0.
  - Next edge: return to IDLE.
  - A request still high in the DONE cycle is not sampled; it is re-sampled in IDLE.
- Latency: grant edge k; bytes transferred cycles k..k+len-1; done high in cycle k+len; earliest next grant at edge k+len+2.
- Read registers hold their value until the next grant of the same port. They are unchanged by writes and by the other port's accesses.
- Request inputs and addresses change freely during XFER/DONE without effect; no preemption.
- Outside XFER: ram_addr=0, ram_wdata=0, ram_we=0, ram_re=0.
- Reset mid-transfer: abort immediately, no done pulse, all registers to reset values.

Test Plan:
1. Data read: RAM[0x100..0x103]=11,22,33,44; d_req, d_we=0, d_addr=0x100 -> ram_re high 4 cycles, addresses 0x100..0x103; d_done pulse in 5th cycle; d_rdata=0x44332211.
2. Data write: d_we=1, d_addr=0x20, d_wdata=0xDEADBEEF -> ram_we 4 cycles with ram_wdata EF,BE,AD,DE at 0x20..0x23; d_done once; d_rdata unchanged.
3. Fetch lengths:
   - i_len=6 at 0x0 -> 6 read cycles, i_done, i_rdata bytes match RAM[0..5].
   - i_len=0 -> single byte.
   - i_len=7 -> clamped to 6.
4. Contention: i_req and d_req held high continuously -> grants alternate data, fetch, data, fetch. Each done is preceded by exactly len strobe cycles. One IDLE cycle separates transfers.
5. Address wrap: d_addr=0xFFFFFFFE read -> ram_addr sequence FFFFFFFE, FFFFFFFF, 00000000, 00000001.
6. Reset asserted in 2nd byte of a data read -> strobes, busy and d_rdata go to 0 immediately; no d_done. After release, a new d_req completes normally.
